// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - parametrised two-read/one-write register file with streaming dump engine
module regfile_dump #(
   parameter int              DATA_W    = 8,
   parameter int              ADDR_W    = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter bit              ZERO_R0   = 1'b0,
   parameter bit              BYPASS    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteR,
   input  logic [DATA_W-1:0] WriteD,
   input  logic [ADDR_W-1:0] Read1,
   input  logic [ADDR_W-1:0] Read2,
   output logic [DATA_W-1:0] ReadD1,
   output logic [DATA_W-1:0] ReadD2,
   input  logic              DumpReq,
   input  logic              DumpReady,
   output logic              DumpValid,
   output logic [ADDR_W-1:0] DumpAddr,
   output logic [DATA_W-1:0] DumpData,
   output logic              DumpBusy,
   output logic              DumpDone
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {IDLE, SCAN} state_t;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              writeEn;
   state_t            state, stateNext;
   logic              validNext, doneNext;
   logic [ADDR_W-1:0] addrNext;
   logic [DATA_W-1:0] dataNext;

   // A write to a hard-wired zero register is dropped entirely, including for bypass.
   assign writeEn = RegWrite && !(ZERO_R0 && (WriteR == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      end else if (writeEn) begin
         regs[WriteR] <= WriteD;
      end
   end

   function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] a);
      if (ZERO_R0 && (a == '0))                 return '0;
      else if (BYPASS && writeEn && (a == WriteR)) return WriteD;
      else                                      return regs[a];
   endfunction

   // Value the register holds after the current edge, regardless of BYPASS.
   function automatic logic [DATA_W-1:0] postEdgeVal(input logic [ADDR_W-1:0] a);
      if (ZERO_R0 && (a == '0))        return '0;
      else if (writeEn && (a == WriteR)) return WriteD;
      else                             return regs[a];
   endfunction

   always_comb begin
      ReadD1 = readPort(Read1);
      ReadD2 = readPort(Read2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         DumpValid <= 1'b0;
         DumpAddr  <= '0;
         DumpData  <= '0;
         DumpDone  <= 1'b0;
      end else begin
         state     <= stateNext;
         DumpValid <= validNext;
         DumpAddr  <= addrNext;
         DumpData  <= dataNext;
         DumpDone  <= doneNext;
      end
   end

   always_comb begin
      stateNext = state;
      validNext = DumpValid;
      addrNext  = DumpAddr;
      dataNext  = DumpData;
      doneNext  = 1'b0;
      case (state)
         IDLE: begin
            if (DumpReq) begin
               stateNext = SCAN;
               validNext = 1'b1;
               addrNext  = '0;
               dataNext  = postEdgeVal('0);
            end
         end
         SCAN: begin
            if (DumpValid && DumpReady) begin
               if (DumpAddr == LAST_ADDR) begin
                  stateNext = IDLE;
                  validNext = 1'b0;
                  addrNext  = '0;
                  dataNext  = '0;
                  doneNext  = 1'b1;
               end else begin
                  addrNext = DumpAddr + ADDR_W'(1);
                  dataNext = postEdgeVal(DumpAddr + ADDR_W'(1));
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign DumpBusy = (state == SCAN);

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed bench for regfile_dump (default, no-bypass and zero-r0 builds)
module tb_regfile_dump;

   logic       clk = 1'b0;
   logic       reset;
   logic       RegWrite;
   logic [1:0] WriteR, Read1, Read2;
   logic [7:0] WriteD;
   logic       DumpReq, DumpReady;

   logic [7:0] aD1, aD2, aData, bD1, bD2, bData, cD1, cD2, cData;
   logic [1:0] aAddr, bAddr, cAddr;
   logic       aValid, aBusy, aDone, bValid, bBusy, bDone, cValid, cBusy, cDone;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   regfile_dump dutA (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
      .Read1(Read1), .Read2(Read2), .ReadD1(aD1), .ReadD2(aD2),
      .DumpReq(DumpReq), .DumpReady(DumpReady), .DumpValid(aValid), .DumpAddr(aAddr),
      .DumpData(aData), .DumpBusy(aBusy), .DumpDone(aDone));

   regfile_dump #(.RESET_VAL(8'h5A), .BYPASS(1'b0)) dutB (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
      .Read1(Read1), .Read2(Read2), .ReadD1(bD1), .ReadD2(bD2),
      .DumpReq(DumpReq), .DumpReady(DumpReady), .DumpValid(bValid), .DumpAddr(bAddr),
      .DumpData(bData), .DumpBusy(bBusy), .DumpDone(bDone));

   regfile_dump #(.ZERO_R0(1'b1)) dutC (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
      .Read1(Read1), .Read2(Read2), .ReadD1(cD1), .ReadD2(cD2),
      .DumpReq(DumpReq), .DumpReady(DumpReady), .DumpValid(cValid), .DumpAddr(cAddr),
      .DumpData(cData), .DumpBusy(cBusy), .DumpDone(cDone));

   typedef struct {
      logic       rw;
      logic [1:0] wr;
      logic [7:0] wd;
      logic [1:0] r1, r2;
      logic [7:0] eA1, eA2, eB1, eB2;
   } vec_t;

   vec_t tbl [7];
   logic [7:0] dumpExp [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBeatA(input string name, input logic v, input logic [1:0] a,
                             input logic [7:0] d, input logic busy, input logic done);
      check({name, ".valid"}, 32'(aValid), 32'(v));
      check({name, ".addr"},  32'(aAddr),  32'(a));
      check({name, ".data"},  32'(aData),  32'(d));
      check({name, ".busy"},  32'(aBusy),  32'(busy));
      check({name, ".done"},  32'(aDone),  32'(done));
   endtask

   task automatic writeReg(input logic [1:0] r, input logic [7:0] d);
      RegWrite = 1'b1; WriteR = r; WriteD = d;
      tick();
      RegWrite = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 2'd0, 8'hAA, 2'd0, 2'd1, 8'hAA, 8'h00, 8'h5A, 8'h5A};
      tbl[1] = '{1'b1, 2'd1, 8'hFF, 2'd0, 2'd1, 8'hAA, 8'hFF, 8'hAA, 8'h5A};
      tbl[2] = '{1'b1, 2'd2, 8'h11, 2'd2, 2'd3, 8'h11, 8'h00, 8'h5A, 8'h5A};
      tbl[3] = '{1'b1, 2'd3, 8'hAB, 2'd3, 2'd2, 8'hAB, 8'h11, 8'h5A, 8'h11};
      tbl[4] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'hAA, 8'hFF, 8'hAA, 8'hFF};
      tbl[5] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'h11, 8'hAB, 8'h11, 8'hAB};
      tbl[6] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'hAB, 8'hAB, 8'hAB, 8'hAB};
      dumpExp[0] = 8'hAA; dumpExp[1] = 8'hFF; dumpExp[2] = 8'h11; dumpExp[3] = 8'hAB;

      reset = 1'b1; RegWrite = 1'b0; WriteR = '0; WriteD = '0;
      Read1 = '0; Read2 = 2'd3; DumpReq = 1'b0; DumpReady = 1'b0;
      repeat (2) tick();
      checkBeatA("reset", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
      check("reset.b_r1", 32'(bD1), 32'h5A);
      check("reset.b_r2", 32'(bD2), 32'h5A);
      reset = 1'b0;
      tick();

      // Table: writes with same-cycle reads, then plain reads
      for (int i = 0; i < 7; i++) begin
         RegWrite = tbl[i].rw; WriteR = tbl[i].wr; WriteD = tbl[i].wd;
         Read1 = tbl[i].r1; Read2 = tbl[i].r2;
         #1;
         check($sformatf("vec%0d.a1", i), 32'(aD1), 32'(tbl[i].eA1));
         check($sformatf("vec%0d.a2", i), 32'(aD2), 32'(tbl[i].eA2));
         check($sformatf("vec%0d.b1", i), 32'(bD1), 32'(tbl[i].eB1));
         check($sformatf("vec%0d.b2", i), 32'(bD2), 32'(tbl[i].eB2));
         tick();
      end

      // Bypass vs no-bypass on write of 5C over reg2=11
      RegWrite = 1'b1; WriteR = 2'd2; WriteD = 8'h5C; Read1 = 2'd2; Read2 = 2'd2;
      #1;
      check("bypass.a", 32'(aD1), 32'h5C);
      check("nobypass.pre", 32'(bD1), 32'h11);
      tick();
      RegWrite = 1'b0;
      #1;
      check("nobypass.post", 32'(bD1), 32'h5C);

      // Zero register build
      RegWrite = 1'b1; WriteR = 2'd0; WriteD = 8'h77; Read1 = 2'd0;
      #1;
      check("zero.nobypass", 32'(cD1), 32'h00);
      tick();
      writeReg(2'd1, 8'h33);
      Read1 = 2'd0; Read2 = 2'd1;
      #1;
      check("zero.r0", 32'(cD1), 32'h00);
      check("zero.r1", 32'(cD2), 32'h33);
      check("nonzero.r0", 32'(aD1), 32'h77);

      for (int i = 0; i < 4; i++) writeReg(2'(i), dumpExp[i]);

      // Full-speed dump
      DumpReq = 1'b1; DumpReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         DumpReq = 1'b0;
         checkBeatA($sformatf("dump.beat%0d", i), 1'b1, 2'(i), dumpExp[i], 1'b1, 1'b0);
      end
      tick();
      checkBeatA("dump.done", 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
      tick();
      check("dump.donepulse", 32'(aDone), 32'h0);

      // Stalled beat 1 with write during stall, same-edge write on transfer
      DumpReq = 1'b1;
      tick();
      DumpReq = 1'b0;
      checkBeatA("stall.beat0", 1'b1, 2'd0, 8'hAA, 1'b1, 1'b0);
      tick();
      checkBeatA("stall.beat1", 1'b1, 2'd1, 8'hFF, 1'b1, 1'b0);
      DumpReady = 1'b0; RegWrite = 1'b1; WriteR = 2'd1; WriteD = 8'h44;
      for (int i = 0; i < 3; i++) begin
         tick();
         RegWrite = 1'b0;
         checkBeatA($sformatf("stall.hold%0d", i), 1'b1, 2'd1, 8'hFF, 1'b1, 1'b0);
      end
      DumpReady = 1'b1; RegWrite = 1'b1; WriteR = 2'd2; WriteD = 8'h99;
      tick();
      RegWrite = 1'b0;
      checkBeatA("stall.beat2", 1'b1, 2'd2, 8'h99, 1'b1, 1'b0);
      tick();
      checkBeatA("stall.beat3", 1'b1, 2'd3, 8'hAB, 1'b1, 1'b0);
      tick();
      check("stall.done", 32'(aDone), 32'h1);
      tick();

      // Reset during beat 2
      DumpReq = 1'b1;
      tick();
      DumpReq = 1'b0;
      tick();
      tick();
      checkBeatA("abort.beat2", 1'b1, 2'd2, 8'h99, 1'b1, 1'b0);
      reset = 1'b1;
      Read1 = 2'd1; Read2 = 2'd2;
      #1;
      checkBeatA("abort.async", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
      check("abort.a_r1", 32'(aD1), 32'h00);
      check("abort.a_r2", 32'(aD2), 32'h00);
      check("abort.b_r1", 32'(bD1), 32'h5A);
      check("abort.b_r2", 32'(bD2), 32'h5A);
      tick();
      reset = 1'b0;
      tick();
      checkBeatA("abort.nodone", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
      check("abort.b_nodone", 32'(bDone), 32'h0);
      DumpReq = 1'b1;
      tick();
      DumpReq = 1'b0;
      checkBeatA("restart.beat0", 1'b1, 2'd0, 8'h00, 1'b1, 1'b0);
      check("restart.b_addr", 32'(bAddr), 32'h0);
      check("restart.b_data", 32'(bData), 32'h5A);
      repeat (3) tick();
      check("restart.b_beat3", 32'({bValid, bAddr, bData}), 32'({1'b1, 2'd3, 8'h5A}));
      tick();
      check("restart.b_done", 32'(bDone), 32'h1);
      check("restart.c_done", 32'(cDone), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
